// File: rtl/spio_link_status_monitor_pkg.sv
// Shared spio link-status definitions: per-link FSM encoding
// and small helpers used by the monitor channels.
package spio_link_status_monitor_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        LINK_SYNC = 2'd1,
        LINK_UP   = 2'd2
    } link_state_e;

    localparam int LINK_STATE_BITS = 2;

    function automatic bit is_link_up(input link_state_e st);
        return st == LINK_UP;
    endfunction

endpackage

// File: rtl/spio_link_status_monitor_if.sv
// Per-link status bundle between the link driver side and a
// status channel; N links wide, CB-bit error counts per link.
interface spio_link_status_monitor_if #(
    parameter int N  = 1,
    parameter int CB = 8
);
    logic [N-1:0]    link_up;
    logic [N-1:0]    vld;
    logic [N-1:0]    rdy;
    logic [N-1:0]    err;
    logic            clear_err;
    logic [N-1:0]    connected;
    logic [N-1:0]    error;
    logic [N-1:0]    activity;
    logic [N*CB-1:0] err_count;

    modport master (
        output link_up,
        output vld,
        output rdy,
        output err,
        output clear_err,
        input  connected,
        input  error,
        input  activity,
        input  err_count
    );

    modport slave (
        input  link_up,
        input  vld,
        input  rdy,
        input  err,
        input  clear_err,
        output connected,
        output error,
        output activity,
        output err_count
    );

endinterface

// File: rtl/spio_link_status_channel.sv
// One link: debounce FSM, error hold timer, saturating error
// counter and registered transfer-activity pulse.
module spio_link_status_channel
    import spio_link_status_monitor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int DEBOUNCE_BITS   = 11,
    parameter int ERROR_HOLD      = 37500000,
    parameter int ERROR_HOLD_BITS = 26,
    parameter int ERR_COUNT_BITS  = 8
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    spio_link_status_monitor_if.slave link
);

    localparam logic [DEBOUNCE_BITS-1:0] DEB_LOAD =
        DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE =
        DEBOUNCE_BITS'(1);
    localparam logic [ERROR_HOLD_BITS-1:0] HOLD_LOAD =
        ERROR_HOLD_BITS'(ERROR_HOLD);
    localparam logic [ERROR_HOLD_BITS-1:0] HOLD_ONE =
        ERROR_HOLD_BITS'(1);
    localparam logic [ERR_COUNT_BITS-1:0] CNT_ONE =
        ERR_COUNT_BITS'(1);
    localparam logic [ERR_COUNT_BITS-1:0] CNT_MAX = '1;

    link_state_e                state_q;
    link_state_e                state_d;
    logic [DEBOUNCE_BITS-1:0]   deb_q;
    logic [DEBOUNCE_BITS-1:0]   deb_d;
    logic [ERROR_HOLD_BITS-1:0] hold_q;
    logic [ERROR_HOLD_BITS-1:0] hold_d;
    logic [ERR_COUNT_BITS-1:0]  cnt_q;
    logic [ERR_COUNT_BITS-1:0]  cnt_d;
    logic                       act_q;
    logic                       act_d;
    logic                       loss;
    logic                       up;
    logic                       event_hit;

    assign up = is_link_up(state_q);

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q <= LINK_DOWN;
            deb_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        loss    = 1'b0;
        unique case (state_q)
            LINK_DOWN: begin
                if (link.link_up[0]) begin
                    state_d = LINK_SYNC;
                    deb_d   = DEB_LOAD;
                end
            end
            LINK_SYNC: begin
                if (!link.link_up[0]) begin
                    state_d = LINK_DOWN;
                end else if (deb_q == '0) begin
                    state_d = LINK_UP;
                end else begin
                    deb_d = deb_q - DEB_ONE;
                end
            end
            LINK_UP: begin
                if (!link.link_up[0]) begin
                    state_d = LINK_DOWN;
                    loss    = 1'b1;
                end
            end
            default: begin
                state_d = LINK_DOWN;
            end
        endcase
    end

    // Strobes outside UP are ignored; a drop from UP is itself an error.
    assign event_hit = (link.err[0] & up) | loss;

    always_comb begin
        hold_d = hold_q;
        if (event_hit) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_ONE;
        end
    end

    // Clear wins over history but not over a same-cycle event.
    always_comb begin
        cnt_d = cnt_q;
        if (link.clear_err) begin
            cnt_d = event_hit ? CNT_ONE : '0;
        end else if (event_hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign act_d = link.vld[0] & link.rdy[0] & up;

    assign link.connected[0] = up;
    assign link.error[0]     = hold_q != '0;
    assign link.activity[0]  = act_q;
    assign link.err_count    = cnt_q;

endmodule

// File: rtl/spio_link_status_monitor.sv
// SpiNNaker-link status monitor: one status channel per link,
// outputs feed the front-panel LED generator.
module spio_link_status_monitor
    import spio_link_status_monitor_pkg::*;
#(
    parameter int NUM_DEVICES     = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int DEBOUNCE_BITS   = 11,
    parameter int ERROR_HOLD      = 37500000,
    parameter int ERROR_HOLD_BITS = 26,
    parameter int ERR_COUNT_BITS  = 8
) (
    input  logic                                CLK_IN,
    input  logic                                RESET_IN,
    input  logic [NUM_DEVICES-1:0]              LINK_UP_IN,
    input  logic [NUM_DEVICES-1:0]              VLD_IN,
    input  logic [NUM_DEVICES-1:0]              RDY_IN,
    input  logic [NUM_DEVICES-1:0]              ERR_IN,
    input  logic                                CLEAR_ERR_IN,
    output logic [NUM_DEVICES-1:0]              CONNECTED_OUT,
    output logic [NUM_DEVICES-1:0]              ERROR_OUT,
    output logic [NUM_DEVICES-1:0]              ACTIVITY_OUT,
    output logic [NUM_DEVICES*ERR_COUNT_BITS-1:0] ERR_COUNT_OUT
);

    for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_link
        spio_link_status_monitor_if #(
            .N  (1),
            .CB (ERR_COUNT_BITS)
        ) lnk ();

        assign lnk.link_up[0] = LINK_UP_IN[i];
        assign lnk.vld[0]     = VLD_IN[i];
        assign lnk.rdy[0]     = RDY_IN[i];
        assign lnk.err[0]     = ERR_IN[i];
        assign lnk.clear_err  = CLEAR_ERR_IN;

        assign CONNECTED_OUT[i] = lnk.connected[0];
        assign ERROR_OUT[i]     = lnk.error[0];
        assign ACTIVITY_OUT[i]  = lnk.activity[0];
        assign ERR_COUNT_OUT[i*ERR_COUNT_BITS +: ERR_COUNT_BITS] =
            lnk.err_count;

        spio_link_status_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE_BITS   (DEBOUNCE_BITS),
            .ERROR_HOLD      (ERROR_HOLD),
            .ERROR_HOLD_BITS (ERROR_HOLD_BITS),
            .ERR_COUNT_BITS  (ERR_COUNT_BITS)
        ) u_chan (
            .CLK_IN   (CLK_IN),
            .RESET_IN (RESET_IN),
            .link     (lnk.slave)
        );
    end

endmodule

// File: doc/spio_link_status_monitor.md
SPIO_LINK_STATUS_MONITOR -- requirements
Module: spio_link_status_monitor

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 4, number of monitored links; one output bit per link feeds the status LED generator.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1024, link-up debounce length; legal range 1 to 2^DEBOUNCE_BITS-1.
REQ-003 SHALL have parameter DEBOUNCE_BITS, default 11, debounce counter width.
REQ-004 SHALL have parameter ERROR_HOLD, default 37500000, error indication hold in cycles; legal range 1 to 2^ERROR_HOLD_BITS-1.
REQ-005 SHALL have parameter ERROR_HOLD_BITS, default 26, hold timer width.
REQ-006 SHALL have parameter ERR_COUNT_BITS, default 8, per-link error counter width.
REQ-007 SHALL have port CLK_IN, input, 1 bit; the single clock, all logic on its rising edge.
REQ-008 SHALL have port RESET_IN, input, 1 bit; synchronous, active-high reset.
REQ-009 SHALL have port LINK_UP_IN, input, NUM_DEVICES bits; raw, possibly bouncing, link-up level per link.
REQ-010 SHALL have port VLD_IN, input, NUM_DEVICES bits; transfer valid per link.
REQ-011 SHALL have port RDY_IN, input, NUM_DEVICES bits; transfer ready per link.
REQ-012 SHALL have port ERR_IN, input, NUM_DEVICES bits; one-cycle error strobe per link.
REQ-013 SHALL have port CLEAR_ERR_IN, input, 1 bit; clears all error counters.
REQ-014 SHALL have port CONNECTED_OUT, output, NUM_DEVICES bits; debounced link-up.
REQ-015 SHALL have port ERROR_OUT, output, NUM_DEVICES bits; stretched error indication.
REQ-016 SHALL have port ACTIVITY_OUT, output, NUM_DEVICES bits; one-cycle pulse per completed transfer.
REQ-017 SHALL have port ERR_COUNT_OUT, output, NUM_DEVICES*ERR_COUNT_BITS bits; link i occupies bits [i*ERR_COUNT_BITS +: ERR_COUNT_BITS].

Function
REQ-018 SHALL run one independent three-state FSM per link: DOWN, SYNC, UP.
REQ-019 DOWN: LINK_UP_IN[i]=1 SHALL move the FSM to SYNC and load the debounce counter with DEBOUNCE_CYCLES-1; otherwise it stays in DOWN.
REQ-020 SYNC: LINK_UP_IN[i]=0 SHALL return the FSM to DOWN; if the counter is 0, the FSM SHALL move to UP; otherwise the counter SHALL decrement.
REQ-021 UP: LINK_UP_IN[i]=0 SHALL move the FSM to DOWN and raise a link-loss error event in that same cycle.
REQ-022 CONNECTED_OUT[i] SHALL be a direct decode of the registered state equal to UP; it asserts on the edge after LINK_UP_IN[i] has been sampled high on DEBOUNCE_CYCLES+1 consecutive edges.
REQ-023 An error event SHALL be (ERR_IN[i] AND state==UP) OR link-loss; ERR_IN[i] outside UP SHALL be ignored.
REQ-024 An error event SHALL load the hold timer with ERROR_HOLD; otherwise a nonzero timer SHALL decrement.
REQ-025 ERROR_OUT[i] SHALL equal (hold timer != 0): high from the edge after the event for exactly ERROR_HOLD cycles; a new event retriggers the full hold.
REQ-026 An error event SHALL increment the link's error counter, which saturates at all-ones and never wraps.
REQ-027 CLEAR_ERR_IN=1 SHALL zero all counters; clear together with an event in the same cycle SHALL yield a count of 1.
REQ-028 ACTIVITY_OUT[i] SHALL be registered VLD_IN[i] AND RDY_IN[i] AND state==UP, one cycle of latency, one pulse per transferring cycle.

Reset
REQ-029 RESET_IN=1 SHALL set every FSM to DOWN and zero all debounce counters, hold timers and error counters; CONNECTED_OUT, ERROR_OUT and ACTIVITY_OUT SHALL read 0 on the edge after reset.
REQ-030 Reset SHALL take priority over all other inputs; reset during SYNC or UP SHALL not raise a link-loss event or increment any counter.

Structure
REQ-031 State encodings (DOWN=0, SYNC=1, UP=2, 2 bits) SHALL live in a shared spio header or package.
REQ-032 Per-link logic (FSM, debounce counter, hold timer, error counter) SHALL be one sub-module, spio_link_status_channel, instanced NUM_DEVICES times by a generate loop; CLEAR_ERR_IN is shared by all instances.

Verification
REQ-033 DEBOUNCE_CYCLES=4, LINK_UP_IN[0] held high -> CONNECTED_OUT[0] rises on the 5th edge after the first high sample.
REQ-034 DEBOUNCE_CYCLES=4, LINK_UP_IN[0] high 3 cycles, low 1 cycle, then high -> FSM returns to DOWN; CONNECTED_OUT[0] stays 0 until 5 consecutive high samples.
REQ-035 ERROR_HOLD=10, link UP, ERR_IN[1] pulsed once -> ERROR_OUT[1] high for exactly 10 cycles and count=1; a second pulse 5 cycles later -> high until 10 cycles after the second pulse and count=2.
REQ-036 Link UP, LINK_UP_IN[2] drops -> CONNECTED_OUT[2]=0 next edge, ERROR_OUT[2]=1, count incremented; ERR_IN[2] while DOWN -> no change.
REQ-037 ERR_COUNT_BITS=2, five error events -> count saturates at 3; CLEAR_ERR_IN coincident with an event -> count=1.
REQ-038 Continuous VLD_IN&RDY_IN on an UP link, with RESET_IN asserted mid-stream -> one ACTIVITY_OUT pulse per cycle, one cycle late; all outputs 0 the edge after reset, with no error event.
